// File: rtl/ram_rr_sched_pkg.sv
// Shared FSM type, slot timing constants and helpers for the round-robin RAM scheduler.
package ram_rr_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GNT  = 3'd1,
        PH1  = 3'd2,
        PH2  = 3'd3,
        PH3  = 3'd4
    } state_t;

    localparam int SLOT_LEN    = 4;  // grant cycle plus three phase cycles
    localparam int RD_LAT      = 3;  // cycles from gnt to rd_vld
    localparam int WR_PH_START = 2;  // first phase that strobes a write

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position inside the slot: 0 outside a slot, 1..3 for the phase cycles.
    function automatic int phase_of(input state_t s);
        case (s)
            PH1:     return 1;
            PH2:     return 2;
            PH3:     return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/ram_rr_sched_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, with wrap.
module ram_rr_sched_rr_pick
    import ram_rr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // Walk the requesters starting at ptr; the first one found wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ram_rr_sched.sv
// Round-robin scheduler sharing one single-port synchronous RAM among NREQ requesters.
// Each access occupies a fixed 4-cycle slot: grant, then three address/data phases.
module ram_rr_sched
    import ram_rr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic               halt,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rd_vld,
    output logic [DW-1:0]      rd_data,
    output logic               ram_cs,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_wdata,
    input  logic [DW-1:0]      ram_rdata,
    output logic               busy
);

    localparam int IW = idx_width(NREQ);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREQ-1:0] rd_vld_q, rd_vld_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;

    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            any;
    logic            grant;
    int              phase;

    ram_rr_sched_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    // A grant is issued combinationally in a grant-eligible cycle so it can never overlap halt.
    assign phase  = phase_of(state_q);
    assign grant  = !RST && !halt && any && ((state_q == IDLE) || (state_q == GNT));
    assign gnt    = grant ? win : '0;
    assign busy   = (phase != 0);
    assign rd_vld = rd_vld_q;
    assign rd_data = rd_data_q;

    // Next-state logic: grant latches the winner's request, then the slot walks PH1..PH3.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, GNT: begin
                if (grant) begin
                    state_d = PH1;
                    ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    idx_d   = win_idx;
                    we_d    = we[win_idx];
                    addr_d  = addr[win_idx*AW +: AW];
                    wdata_d = wdata[win_idx*DW +: DW];
                end else begin
                    state_d = IDLE;
                end
            end
            PH1:     state_d = PH2;
            PH2:     state_d = PH3;
            PH3:     state_d = (|req) ? GNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM drive: reads strobe in phases 1-2, writes present the address in phase 1 and strobe in 2-3.
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (phase != 0) begin
            if (we_q) begin
                ram_addr = addr_q;
                if (phase >= WR_PH_START && phase < SLOT_LEN) begin
                    ram_cs    = 1'b1;
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q;
                end
            end else if (phase < RD_LAT) begin
                ram_cs   = 1'b1;
                ram_addr = addr_q;
            end
        end
    end

    // Read return: capture the RAM output answering the first read strobe, pulse rd_vld next cycle.
    always_comb begin
        rd_vld_d  = '0;
        rd_data_d = '0;
        if (phase == RD_LAT - 1 && !we_q) begin
            rd_vld_d[idx_q] = 1'b1;
            rd_data_d       = ram_rdata;
        end
    end

    // Slot state, pointer, latched request payload and read-return registers.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
        if (RST) begin
            // NOTE: the payload registers are cleared as well, so the RAM drive is all-zero straight out of reset.
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ram_rr_sched.sv
// Self-checking bench for ram_rr_sched: directed scenarios plus randomized traffic
// checked every cycle against a slot-level reference model and a RAM shadow copy.
module tb_ram_rr_sched;

    localparam int NREQ    = 4;
    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int LAT_MAX = 4 * NREQ;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic               halt;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rd_vld;
    logic [DW-1:0]      rd_data;
    logic               ram_cs;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      ram_rdata;
    logic               busy;

    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;
    logic [NREQ-1:0] last_gnt = '0;
    int              rise_t [NREQ];
    logic            lat_en = 1'b0;
    int              gi [$];
    int              gc [$];

    ram_rr_sched #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .halt      (halt),
        .gnt       (gnt),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Cycle index; a cycle starts at its posedge.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 'h15) ? 16'hBEEF : DW'((a * 257) ^ 'h5A5A);
    endfunction

    // RAM macro model: synchronous single port, read data one cycle after cs.
    logic [DW-1:0] mem [2**AW];
    initial begin
        for (int a = 0; a < 2**AW; a++) mem[a] = init_val(a);
        ram_rdata = '0;
        forever begin
            @(posedge CLK);
            if (ram_cs && ram_we)  mem[ram_addr] <= ram_wdata;
            if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
        end
    end

    // Reference model: one slot at a time, RR pointer, shadow memory; checked on every negedge.
    logic [DW-1:0] shadow [2**AW];
    initial begin : model
        bit              s_act;
        int              s_g, s_w, k, w;
        bit              s_we;
        logic [AW-1:0]   s_addr;
        logic [DW-1:0]   s_wdata, s_rd;
        int              m_ptr;
        logic [NREQ-1:0] e_gnt, e_vld;
        logic            e_busy, e_cs, e_we;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wdata, e_rdata;
        for (int a = 0; a < 2**AW; a++) shadow[a] = init_val(a);
        s_act = 0; m_ptr = 0; s_g = 0; s_w = 0; s_we = 0;
        s_addr = '0; s_wdata = '0; s_rd = '0;
        forever begin
            @(negedge CLK);
            e_gnt = '0; e_vld = '0; e_busy = 0; e_cs = 0; e_we = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; w = -1; k = 0;
            if (s_act) begin
                k = cyc - s_g;
                e_busy = 1;
                if (s_we) begin
                    e_addr = s_addr;
                    if (k >= 2) begin e_cs = 1; e_we = 1; e_wdata = s_wdata; end
                    if (k == 2) shadow[s_addr] = s_wdata;
                end else begin
                    if (k <= 2) begin e_cs = 1; e_addr = s_addr; end
                    if (k == 3) begin e_vld[s_w] = 1'b1; e_rdata = s_rd; end
                end
            end else if (!RST && !halt) begin
                for (int j = 0; j < NREQ; j++)
                    if (w < 0 && req[(m_ptr + j) % NREQ]) w = (m_ptr + j) % NREQ;
                if (w >= 0) e_gnt[w] = 1'b1;
            end
            check("gnt", gnt, e_gnt);
            check("busy", busy, e_busy);
            check("ram_cs", ram_cs, e_cs);
            check("ram_we", ram_we, e_we);
            check("ram_addr", ram_addr, e_addr);
            check("ram_wdata", ram_wdata, e_wdata);
            check("rd_vld", rd_vld, e_vld);
            if (e_vld != '0) check("rd_data", rd_data, e_rdata);
            if (w >= 0 && lat_en) check("grant_latency_ok", (cyc - rise_t[w]) <= LAT_MAX, 1);
            last_gnt = gnt;
            if (s_act && k == 3) s_act = 0;
            if (RST) begin
                s_act = 0;
                m_ptr = 0;
            end else if (w >= 0) begin
                s_act   = 1;
                s_g     = cyc;
                s_w     = w;
                s_we    = we[w];
                s_addr  = addr[w*AW +: AW];
                s_wdata = wdata[w*DW +: DW];
                s_rd    = shadow[addr[w*AW +: AW]];
                m_ptr   = (w + 1) % NREQ;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]             = 1'b1;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
        rise_t[i]          = cyc;
    endtask

    task automatic wait_gnt(input int i, input int budget, output int g);
        g = -1;
        for (int k = 0; k < budget && g < 0; k++) begin
            @(negedge CLK);
            if (gnt[i]) g = cyc;
        end
        check($sformatf("gnt%0d_within_%0d", i, budget), g >= 0, 1);
    endtask

    initial begin : stim
        int g, rel, cnt;
        RST = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; halt = 1'b0;
        for (int i = 0; i < NREQ; i++) rise_t[i] = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_gnt", gnt, 0);
        check("rst_outputs", {busy, ram_cs, ram_we, rd_vld}, 0);
        step();
        RST = 1'b0;

        // 1: read of a preloaded word
        set_req(2, 1'b0, 8'h15, '0);
        wait_gnt(2, 4, g);
        step();
        req[2] = 1'b0;
        @(negedge CLK);
        check("t1_cs_g1", ram_cs, 1);
        check("t1_addr_g1", ram_addr, 8'h15);
        repeat (2) @(negedge CLK);
        check("t1_rd_vld_g3", rd_vld, 4'b0100);
        check("t1_rd_data_g3", rd_data, 16'hBEEF);

        // 2: write, then read it back
        step();
        set_req(1, 1'b1, 8'h20, 16'h1234);
        wait_gnt(1, 8, g);
        step();
        req[1] = 1'b0;
        @(negedge CLK);
        check("t2_cs_g1", {ram_cs, ram_addr}, {1'b0, 8'h20});
        for (int k = 2; k <= 3; k++) begin
            @(negedge CLK);
            check($sformatf("t2_strobe_g%0d", k), {ram_cs, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h20, 16'h1234});
        end
        step();
        set_req(1, 1'b0, 8'h20, '0);
        wait_gnt(1, 8, g);
        step();
        req[1] = 1'b0;
        repeat (3) @(negedge CLK);
        check("t2_readback", {rd_vld, rd_data}, {4'b0010, 16'h1234});

        // 3: all requesters held from reset
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        rel = cyc;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8'h50 + i), '0);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            for (int i = 0; i < NREQ; i++)
                if (gnt[i]) begin gi.push_back(i); gc.push_back(cyc); end
        end
        step();
        req = '0;
        check("t3_ngrants", gi.size(), 5);
        for (int k = 0; k < 5 && k < gi.size(); k++) begin
            check($sformatf("t3_order_%0d", k), gi[k], k % NREQ);
            check($sformatf("t3_time_%0d", k), gc[k] - rel, 4 * k);
        end
        repeat (4) @(negedge CLK);

        // 4: halt rises at G+1 of a read slot with req[3] pending
        step();
        set_req(0, 1'b0, 8'h40, '0);
        wait_gnt(0, 8, g);
        step();
        req[0] = 1'b0;
        halt   = 1'b1;
        set_req(3, 1'b0, 8'h41, '0);
        cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (gnt != '0) cnt++;
            if (k == 3) check("t4_rd_vld_g3", rd_vld, 4'b0001);
        end
        check("t4_no_gnt_while_halt", cnt, 0);
        step();
        halt = 1'b0;
        @(negedge CLK);
        check("t4_gnt_on_release", gnt, 4'b1000);
        step();
        req[3] = 1'b0;
        repeat (4) @(negedge CLK);

        // 5: reset at G+2 of a write slot
        step();
        set_req(2, 1'b1, 8'h30, 16'hCAFE);
        wait_gnt(2, 8, g);
        step();
        req[2] = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        check("t5_quiet_after_rst", {ram_cs, ram_we, busy, rd_vld}, 0);
        step();
        set_req(1, 1'b0, 8'h30, '0);
        set_req(3, 1'b0, 8'h31, '0);
        @(negedge CLK);
        check("t5_ptr_reset", gnt, 4'b0010);
        step();
        req[1] = 1'b0;
        wait_gnt(3, 8, g);
        step();
        req[3] = 1'b0;
        repeat (4) @(negedge CLK);

        // 6: random traffic; latency bound checked while halt stays low
        for (int c = 0; c < 10000; c++) begin
            step();
            lat_en = (c < 5000);
            if (c >= 5000 && $urandom_range(0, 9) == 0) halt = ~halt;
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i]) begin
                    req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
        end
        step();
        halt   = 1'b0;
        req    = '0;
        lat_en = 1'b0;
        repeat (8) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
